// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM stage: controller states and the MEM/WB bundle.
package mem_wb_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] dato_mem;
    logic [WORD_W-1:0] alu_res;
    logic              mux_d;
    logic [4:0]        rd;
    logic              reg_write;
  } memwb_t;
endpackage

// File: rtl/memoria_datos.sv
// Single-port word RAM with synchronous write and registered, enable-gated read.
module memoria_datos
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Read data is only refreshed on an enabled read so it stays put while the bundle is held.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/etapa_mem_wb.sv
// MEM stage: accepts EX/MEM bundles, resolves branches, accesses data memory
// with a fixed latency and presents a registered MEM/WB bundle under backpressure.
module etapa_mem_wb
  import mem_wb_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_add_res,
  input  logic        in_zero_flag,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_dato_lec2,
  input  logic        in_mux_d,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_branch,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_dato_mem,
  output logic [31:0] out_alu_res,
  output logic        out_mux_d,
  output logic [4:0]  out_rd,
  output logic        out_reg_write
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, is_mem, last_cyc;
  logic              ram_we, ram_re;
  logic [AW-1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q, ram_rdata;
  logic              ld_q, st_q, pc_src_q;
  logic [31:0]       pc_target_q, alu_res_q;
  logic              mux_d_q, reg_write_q;
  logic [4:0]        rd_q;
  memwb_t            wb;

  assign accept   = in_valid & in_ready;
  assign is_mem   = in_mem_read | in_mem_write;
  assign last_cyc = (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = is_mem ? ACCESS : HOLD;
      ACCESS:  if (last_cyc) state_d = HOLD;
               else cnt_d = cnt_q - 4'd1;
      HOLD:    if (out_ready) state_d = accept ? (is_mem ? ACCESS : HOLD) : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) cnt_d = LAT_INIT;
  end

  // Memory side effects are suppressed under reset so a pending store never lands.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    unique case (state_q)
      IDLE:   in_ready = 1'b1;
      ACCESS: begin
        ram_we = last_cyc & st_q & ~rst;
        ram_re = last_cyc & ld_q & ~rst;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      alu_res_q   <= '0;
      mux_d_q     <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      pc_src_q <= accept & in_branch & in_zero_flag;
      if (accept) begin
        pc_target_q <= in_add_res;
        ld_q        <= in_mem_read & ~in_mem_write;
        st_q        <= in_mem_write;
        alu_res_q   <= in_alu_res;
        mux_d_q     <= in_mux_d;
        rd_q        <= in_rd;
        reg_write_q <= in_reg_write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= in_alu_res[AW+1:2];
      wdata_q <= in_dato_lec2;
    end
  end

  memoria_datos #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wb.dato_mem  = ld_q ? ram_rdata : '0;
    wb.alu_res   = alu_res_q;
    wb.mux_d     = mux_d_q;
    wb.rd        = rd_q;
    wb.reg_write = reg_write_q;
  end

  assign pc_src        = pc_src_q;
  assign pc_target     = pc_target_q;
  assign out_dato_mem  = wb.dato_mem;
  assign out_alu_res   = wb.alu_res;
  assign out_mux_d     = wb.mux_d;
  assign out_rd        = wb.rd;
  assign out_reg_write = wb.reg_write;
endmodule

// File: tb/tb_etapa_mem_wb.sv
// Directed bench for etapa_mem_wb with DEPTH = 256, MEM_LAT = 2.
module tb_etapa_mem_wb;
  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_add_res, in_alu_res, in_dato_lec2;
  logic        in_zero_flag, in_mux_d, in_mem_read, in_mem_write, in_branch, in_reg_write;
  logic [4:0]  in_rd;
  logic        pc_src, out_valid, out_ready, out_mux_d, out_reg_write;
  logic [31:0] pc_target, out_dato_mem, out_alu_res;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  etapa_mem_wb #(.DEPTH(256), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_add_res(in_add_res), .in_zero_flag(in_zero_flag),
    .in_alu_res(in_alu_res), .in_dato_lec2(in_dato_lec2),
    .in_mux_d(in_mux_d), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_branch(in_branch), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .pc_src(pc_src), .pc_target(pc_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dato_mem(out_dato_mem), .out_alu_res(out_alu_res),
    .out_mux_d(out_mux_d), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                       input logic br, input logic zf, input logic md, input logic rw,
                       input logic [4:0] rdst, input logic [31:0] alu,
                       input logic [31:0] dat, input logic [31:0] add);
    in_valid     = v;
    in_mem_read  = rd_en;
    in_mem_write = wr_en;
    in_branch    = br;
    in_zero_flag = zf;
    in_mux_d     = md;
    in_reg_write = rw;
    in_rd        = rdst;
    in_alu_res   = alu;
    in_dato_lec2 = dat;
    in_add_res   = add;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_pc_src", pc_src, 0);
    check("rst_pc_target", pc_target, 0);
    check("rst_dato", out_dato_mem, 0);
    check("rst_alu", out_alu_res, 0);
    check("rst_rd", out_rd, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;

    // Store 0xDEADBEEF at 0x10
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h0);
    check("st_in_ready", in_ready, 1);
    step(); idle();
    check("st_lat0", out_valid, 0);
    check("st_acc_in_ready", in_ready, 0);
    step();
    check("st_lat1", out_valid, 0);
    step();
    check("st_valid", out_valid, 1);
    check("st_dato_zero", out_dato_mem, 0);

    // Load 0x10 right after the store
    drive(1, 1, 0, 0, 0, 1, 1, 5'd5, 32'h10, 32'h0, 32'h0);
    step(); idle();
    check("ld_lat0", out_valid, 0);
    step();
    check("ld_lat1", out_valid, 0);
    step();
    check("ld_valid", out_valid, 1);
    check("ld_dato", out_dato_mem, 32'hDEADBEEF);
    check("ld_rd", out_rd, 5);
    check("ld_mux_d", out_mux_d, 1);
    check("ld_reg_write", out_reg_write, 1);
    check("ld_alu", out_alu_res, 32'h10);
    check("ld_pc_src", pc_src, 0);

    // Taken branch
    drive(1, 0, 0, 1, 1, 0, 0, 5'd0, 32'h0, 32'h0, 32'h40);
    step(); idle();
    check("br_pc_src", pc_src, 1);
    check("br_pc_target", pc_target, 32'h40);
    check("br_valid", out_valid, 1);
    step();
    check("br_pulse_end", pc_src, 0);
    check("br_to_idle", out_valid, 0);

    // Not-taken branch
    drive(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h80);
    step(); idle();
    check("nbr_pc_src", pc_src, 0);
    check("nbr_valid", out_valid, 1);
    step();

    // Backpressure on an R-type bundle
    out_ready = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1, 5'd3, 32'h1234, 32'h0, 32'h0);
    step();
    drive(1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h5678, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_alu", out_alu_res, 32'h1234);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step(); idle();
    check("bp_next_alu", out_alu_res, 32'h5678);
    check("bp_next_rd", out_rd, 7);
    check("bp_next_valid", out_valid, 1);
    step();

    // Address wrap and byte-offset ignore: 0x403 aliases word 0
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h403, 32'hA5A5A5A5, 32'h0);
    step(); idle(); step(); step();
    check("wrap_st_valid", out_valid, 1);
    drive(1, 1, 0, 0, 0, 1, 1, 5'd1, 32'h0, 32'h0, 32'h0);
    step(); idle(); step(); step();
    check("wrap_ld_valid", out_valid, 1);
    check("wrap_ld_dato", out_dato_mem, 32'hA5A5A5A5);

    // Reset during ACCESS drops the pending store
    drive(1, 0, 1, 0, 0, 0, 0, 5'd0, 32'h20, 32'h22222222, 32'h0);
    step(); idle(); step(); step();
    drive(1, 0, 1, 1, 1, 0, 0, 5'd0, 32'h20, 32'h11111111, 32'h99);
    step();
    check("rstacc_pre_pc_src", pc_src, 1);
    check("rstacc_pre_alu", out_alu_res, 32'h20);
    rst = 1'b1;
    idle();
    step();
    check("rstacc_valid", out_valid, 0);
    check("rstacc_pc_src", pc_src, 0);
    check("rstacc_pc_target", pc_target, 0);
    check("rstacc_alu", out_alu_res, 0);
    check("rstacc_dato", out_dato_mem, 0);
    rst = 1'b0;
    step();
    check("rstacc_after_valid", out_valid, 0);
    check("rstacc_after_target", pc_target, 0);
    check("rstacc_after_ready", in_ready, 1);
    drive(1, 1, 0, 0, 0, 1, 1, 5'd9, 32'h20, 32'h0, 32'h0);
    step(); idle(); step(); step();
    check("rstacc_ld_valid", out_valid, 1);
    check("rstacc_ld_dato", out_dato_mem, 32'h22222222);

    // Read and write both set acts as a store
    drive(1, 1, 1, 0, 0, 1, 1, 5'd2, 32'h8, 32'h7, 32'h0);
    step(); idle(); step(); step();
    check("rw_valid", out_valid, 1);
    check("rw_dato_zero", out_dato_mem, 0);
    drive(1, 1, 0, 0, 0, 1, 1, 5'd2, 32'h8, 32'h0, 32'h0);
    step(); idle(); step(); step();
    check("rw_ld_dato", out_dato_mem, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/etapa_mem_wb.md
# etapa_mem_wb

Memory-stage controller that sits at the consuming end of the EX/MEM buffer. It accepts one EX/MEM bundle at a time over a valid/ready handshake and resolves the branch decision. It performs the load or store against an internal word-addressed data memory with configurable latency, then presents a registered MEM/WB bundle under valid/ready backpressure to the write-back stage.

## Interface
- DEPTH, 256: data memory depth in 32-bit words; power of two, ≥ 4.
- MEM_LAT, 2: memory access cycles for loads and stores; range 1..15.
- Clocking/reset (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  EX/MEM bundle present.
- in_ready  out  1  block can accept the bundle this cycle.
- in_add_res  in  32  branch target from EX adder.
- in_zero_flag  in  1  ALU zero flag.
- in_alu_res  in  32  ALU result; byte address for memory ops.
- in_dato_lec2  in  32  store data (register read port 2).
- in_mux_d  in  1  write-back select: 1 = memory data, 0 = ALU result.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_branch  in  1  conditional branch.
- in_rd  in  5  destination register.
- in_reg_write  in  1  register-file write enable.
- pc_src  out  1  one-cycle pulse: branch taken.
- pc_target  out  32  target, valid while pc_src = 1.
- out_valid  out  1  MEM/WB bundle present.
- out_ready  in  1  write-back stage consumes the bundle.
- out_dato_mem  out  32  load data (0 for non-loads).
- out_alu_res  out  32  registered in_alu_res.
- out_mux_d, out_rd, out_reg_write  out  1/5/1  registered pass-through.

## Operation
- FSM states: IDLE, ACCESS, HOLD.
- in_ready = (state == IDLE) or (state == HOLD and out_ready).
- Accept occurs when in_valid and in_ready; all bundle fields are captured on that edge.
- Accept with in_mem_read or in_mem_write goes to ACCESS, with the latency counter loaded to MEM_LAT−1. Any other accept goes to HOLD.
- ACCESS decrements each cycle. At count 0 the load data is captured or the store is committed, and the FSM goes to HOLD.
- HOLD: out_valid = 1.
  - out_ready without a new accept goes to IDLE.
  - out_ready with a new accept follows the accept rule above.
- Address = in_alu_res[log2(DEPTH)+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so the address wraps modulo DEPTH.
- Read and write both set: treated as a store; out_dato_mem = 0.
- pc_src = registered (in_branch & in_zero_flag) on the accept edge, high for exactly one cycle. pc_target is captured from in_add_res on the same edge.
- The memory array is not cleared by reset.

## Timing
- Reset: state IDLE, out_valid 0, pc_src 0. pc_target, out_dato_mem, out_alu_res, out_rd, out_mux_d and out_reg_write are all 0.
- Accept at edge T, non-memory op: out_valid from T+1.
- Accept at edge T, memory op: out_valid from T+MEM_LAT+1.
- Store write occurs on edge T+MEM_LAT.
- pc_src is high in cycle T+1 only, independent of memory latency.
- Outputs are held stable while out_valid = 1 and out_ready = 0.
- Back-to-back throughput: non-memory ops sustain one per cycle when out_ready = 1. Memory ops sustain one per MEM_LAT+1 cycles.
- rst mid-ACCESS: the FSM returns to IDLE, the pending store is not written, and the load is discarded. rst wins over every simultaneous event.
- A load at the same address as an immediately preceding store returns the stored value, because the store commits before the load's read edge.

## Structure
- Shared package `mem_wb_pkg`:
  - state enum {IDLE, ACCESS, HOLD};
  - MEM/WB bundle struct (dato_mem, alu_res, mux_d, rd, reg_write);
  - constant WORD_W = 32.
- One sub-module: `memoria_datos`, a single-port synchronous word RAM (DEPTH × 32) with write enable and registered read. The FSM and handshake stay in the top.

## Test plan
- Store then load, MEM_LAT = 2: store in_alu_res = 0x10, in_dato_lec2 = 0xDEADBEEF, then load 0x10 → out_valid 3 cycles after the load accept, out_dato_mem = 0xDEADBEEF.
- Branch: in_branch = 1, in_zero_flag = 1, in_add_res = 0x40 → pc_src high for one cycle after accept, pc_target = 0x40. With in_zero_flag = 0 → pc_src stays 0.
- Backpressure: R-type with in_alu_res = 0x1234 and out_ready = 0 for 5 cycles → out_valid held, out_alu_res = 0x1234 stable, in_ready = 0. Then out_ready = 1 → next bundle accepted in the same cycle.
- Wrap and alignment, DEPTH = 256: store 0xA5A5A5A5 at 0x403, then load 0x000 → returns 0xA5A5A5A5.
- Reset mid-ACCESS: store 0x11111111 to 0x20, assert rst during the first ACCESS cycle, then load 0x20 → old contents returned. All outputs read 0 during and immediately after reset.
- Read and write both set at 0x8 with data 0x7 → memory[2] = 0x7, out_dato_mem = 0.
